// File: rtl/spi_master.sv
// SPI mode-0 master: MSB-first words, SCLK = clk / (2*CLK_DIV), optional SSEL hold across words.
// Every SPI pin comes straight from a flop; MISO is already synchronous to clk.
module spi_master #(
    parameter int PACKET_WIDTH = 8,
    parameter int CLK_DIV      = 5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [PACKET_WIDTH-1:0] txData,
    input  logic                    start,
    input  logic                    hold,
    output logic                    busy,
    output logic [PACKET_WIDTH-1:0] rxData,
    output logic                    done,
    output logic                    spi_SCLK,
    output logic                    spi_SSEL,
    output logic                    spi_MOSI,
    input  logic                    spi_MISO
);
    localparam int              BW       = $clog2(PACKET_WIDTH);
    localparam logic [7:0]      CNT_LAST = 8'(CLK_DIV - 1);
    localparam logic [BW-1:0]   BIT_LAST = BW'(PACKET_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, HELD} state_t;

    state_t                  state_q;
    logic [7:0]              cnt_q;
    logic [BW-1:0]           bit_q;
    logic [PACKET_WIDTH-1:0] shreg_q;
    logic [PACKET_WIDTH-1:0] rx_q;
    logic                    busy_q, done_q, sclk_q, ssel_q, mosi_q;
    logic                    phase_end;

    assign phase_end = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            rx_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            ssel_q  <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, HELD: begin
                    if (start) begin
                        shreg_q <= txData;
                        mosi_q  <= txData[PACKET_WIDTH-1];
                        ssel_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= LEAD;
                    end else if (state_q == HELD && !hold) begin
                        ssel_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                LEAD: begin
                    if (phase_end) begin
                        cnt_q   <= '0;
                        sclk_q  <= 1'b1;
                        state_q <= HIGH;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        cnt_q   <= '0;
                        sclk_q  <= 1'b0;
                        // Shift in MISO; the pre-shift bit below MSB is the next MOSI bit.
                        shreg_q <= {shreg_q[PACKET_WIDTH-2:0], spi_MISO};
                        if (bit_q != BIT_LAST) mosi_q <= shreg_q[PACKET_WIDTH-2];
                        state_q <= LOW;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        cnt_q <= '0;
                        if (bit_q == BIT_LAST) begin
                            done_q <= 1'b1;
                            rx_q   <= shreg_q;
                            busy_q <= 1'b0;
                            bit_q  <= '0;
                            if (hold) begin
                                state_q <= HELD;
                            end else begin
                                ssel_q  <= 1'b1;
                                state_q <= IDLE;
                            end
                        end else begin
                            bit_q   <= bit_q + BW'(1);
                            sclk_q  <= 1'b1;
                            state_q <= HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rxData   = rx_q;
    assign spi_SCLK = sclk_q;
    assign spi_SSEL = ssel_q;
    assign spi_MOSI = mosi_q;
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback, slave model, SSEL hold, ignored start,
// async reset abort, and a CLK_DIV=1 / 16-bit instance with MISO tied high.
module tb_spi_master;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] txData = '0;
    logic       start = 1'b0, hold = 1'b0;
    logic       busy, done, sclk, ssel, mosi, miso;
    logic [7:0] rxData;
    logic       loopback = 1'b1;
    logic [7:0] slv_word = 8'h5A;
    int         slv_idx = 0;

    logic [15:0] tx16 = '0;
    logic        start16 = 1'b0;
    logic        busy16, done16, sclk16, ssel16, mosi16;
    logic [15:0] rx16;

    int total = 0, bad = 0;
    int rise_cnt = 0, done_cnt = 0, ssel_rise = 0, mosi_viol = 0;
    logic sclk_p = 1'b0, ssel_p = 1'b1, mosi_p = 1'b0;

    // Slave shifts out slv_word MSB first, advancing on each SCLK falling edge.
    assign miso = loopback ? mosi : slv_word[3'(7 - slv_idx)];

    spi_master dut (
        .clk(clk), .reset_n(reset_n), .txData(txData), .start(start), .hold(hold),
        .busy(busy), .rxData(rxData), .done(done), .spi_SCLK(sclk), .spi_SSEL(ssel),
        .spi_MOSI(mosi), .spi_MISO(miso)
    );

    spi_master #(.PACKET_WIDTH(16), .CLK_DIV(1)) dut16 (
        .clk(clk), .reset_n(reset_n), .txData(tx16), .start(start16), .hold(1'b0),
        .busy(busy16), .rxData(rx16), .done(done16), .spi_SCLK(sclk16), .spi_SSEL(ssel16),
        .spi_MOSI(mosi16), .spi_MISO(1'b1)
    );

    always @(negedge clk) begin
        sclk_p <= sclk;
        ssel_p <= ssel;
        mosi_p <= mosi;
        if (sclk && !sclk_p) rise_cnt <= rise_cnt + 1;
        if (sclk && !sclk_p && mosi !== mosi_p) mosi_viol <= mosi_viol + 1;
        if (ssel && !ssel_p) ssel_rise <= ssel_rise + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (ssel) slv_idx <= 0;
        else if (!sclk && sclk_p && slv_idx < 7) slv_idx <= slv_idx + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic settle;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Drive start for one acceptance edge, then check the first LEAD cycle.
    task automatic start_word(input logic [7:0] tx, input logic h, input string tag);
        @(negedge clk);
        txData = tx;
        hold   = h;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_busy1"}, 32'(busy), 32'd1);
        chk({tag, "_ssel0"}, 32'(ssel), 32'd0);
        chk({tag, "_mosi_msb"}, 32'(mosi), 32'(tx[7]));
    endtask

    // Cycles from the acceptance cycle to the done cycle; -1 on timeout.
    task automatic wait_done(input int inj, output int lat);
        lat = -1;
        for (int i = 1; i <= 2000; i++) begin
            @(negedge clk);
            if (i == inj) begin
                start  = 1'b1;
                txData = 8'h55;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int lat, r0, d0, s0, v0;

        #2 reset_n = 1'b0;
        #1;
        chk("rst_ssel", 32'(ssel), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rx", 32'(rxData), 32'd0);
        chk("rst_ssel16", 32'(ssel16), 32'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        settle();

        // Loopback 0xAB
        r0 = rise_cnt; d0 = done_cnt; s0 = ssel_rise;
        start_word(8'hAB, 1'b0, "lb");
        wait_done(0, lat);
        chk("lb_latency", 32'(lat), 32'd86);
        chk("lb_rx", 32'(rxData), 32'hAB);
        chk("lb_busy_done", 32'(busy), 32'd0);
        chk("lb_ssel_done", 32'(ssel), 32'd1);
        chk("lb_mosi_last", 32'(mosi), 32'd1);
        settle();
        chk("lb_rises", 32'(rise_cnt - r0), 32'd8);
        chk("lb_dones", 32'(done_cnt - d0), 32'd1);
        chk("lb_ssel_rises", 32'(ssel_rise - s0), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("lb_rx_held", 32'(rxData), 32'hAB);

        // Slave returns 0x5A while master sends 0x15
        loopback = 1'b0;
        v0 = mosi_viol;
        start_word(8'h15, 1'b0, "slv");
        wait_done(0, lat);
        chk("slv_latency", 32'(lat), 32'd86);
        chk("slv_rx", 32'(rxData), 32'h5A);
        settle();
        chk("slv_mosi_stable", 32'(mosi_viol - v0), 32'd0);
        loopback = 1'b1;

        // Held SSEL across two words, then release
        r0 = rise_cnt; s0 = ssel_rise;
        start_word(8'hAB, 1'b1, "h1");
        wait_done(0, lat);
        chk("h1_latency", 32'(lat), 32'd86);
        chk("h1_rx", 32'(rxData), 32'hAB);
        chk("h1_ssel_done", 32'(ssel), 32'd0);
        start_word(8'h15, 1'b1, "h2");
        wait_done(0, lat);
        chk("h2_latency", 32'(lat), 32'd86);
        chk("h2_rx", 32'(rxData), 32'h15);
        settle();
        chk("h_rises", 32'(rise_cnt - r0), 32'd16);
        chk("h_ssel_rises", 32'(ssel_rise - s0), 32'd0);
        @(negedge clk);
        hold = 1'b0;
        chk("h_ssel_still_low", 32'(ssel), 32'd0);
        @(posedge clk);
        #1;
        chk("h_ssel_release", 32'(ssel), 32'd1);
        settle();

        // start coinciding with !hold in HELD: start wins
        s0 = ssel_rise;
        start_word(8'hAB, 1'b1, "sw1");
        wait_done(0, lat);
        start_word(8'h3C, 1'b0, "sw2");
        wait_done(0, lat);
        chk("sw_rx", 32'(rxData), 32'h3C);
        chk("sw_ssel_done", 32'(ssel), 32'd1);
        settle();
        chk("sw_ssel_rises", 32'(ssel_rise - s0), 32'd1);

        // start pulsed mid-transfer is ignored
        d0 = done_cnt;
        start_word(8'hAB, 1'b0, "ign");
        wait_done(40, lat);
        chk("ign_latency", 32'(lat), 32'd86);
        chk("ign_rx", 32'(rxData), 32'hAB);
        repeat (200) @(posedge clk);
        settle();
        chk("ign_dones", 32'(done_cnt - d0), 32'd1);

        // Async reset during bit 4 aborts the word
        d0 = done_cnt;
        start_word(8'hAB, 1'b0, "rab");
        repeat (38) @(negedge clk);
        chk("rab_sclk_hi", 32'(sclk), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rab_ssel", 32'(ssel), 32'd1);
        chk("rab_sclk", 32'(sclk), 32'd0);
        chk("rab_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        settle();
        chk("rab_no_done", 32'(done_cnt - d0), 32'd0);
        start_word(8'hFF, 1'b0, "ff");
        wait_done(0, lat);
        chk("ff_latency", 32'(lat), 32'd86);
        chk("ff_rx", 32'(rxData), 32'hFF);

        // 16-bit, CLK_DIV=1, MISO tied high
        @(negedge clk);
        tx16 = 16'h1234;
        start16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        chk("w16_busy", 32'(busy16), 32'd1);
        lat = -1;
        for (int i = 1; i <= 500; i++) begin
            @(negedge clk);
            if (done16) begin
                lat = i;
                break;
            end
        end
        chk("w16_latency", 32'(lat), 32'd34);
        chk("w16_rx", 32'(rx16), 32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
